// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the logic it resets.
// Optional feature macro: PLL_RELOCK_CNT_EN (adds the relock_cnt debug counter).
interface pll_reset_sequencer_if;
  logic       pll_lock;
  logic       sys_rst_n;
  logic       dram_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [2:0] state_o;
`ifdef PLL_RELOCK_CNT_EN
  logic [7:0] relock_cnt;
`endif

  // Sequencer side: consumes raw lock, drives the reset/status outputs
  modport master (
    input  pll_lock,
    output sys_rst_n,
    output dram_rst_n,
    output ready,
    output lock_lost,
`ifdef PLL_RELOCK_CNT_EN
    output relock_cnt,
`endif
    output state_o
  );

  // Consumer side: supplies raw lock, observes the outputs
  modport slave (
    output pll_lock,
    input  sys_rst_n,
    input  dram_rst_n,
    input  ready,
    input  lock_lost,
`ifdef PLL_RELOCK_CNT_EN
    input  relock_cnt,
`endif
    input  state_o
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Ordered reset release downstream of the PLL: synchronises the raw lock,
// waits for it to be stable, releases the system reset, then after a
// power-up delay releases the DRAM reset. Any lock drop re-asserts all resets.
// Optional feature macro: PLL_RELOCK_CNT_EN (saturating RUN->WAIT_LOCK counter).
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned DRAM_DELAY_CYCLES  = 30000,
  parameter int unsigned CNT_W              = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABILIZE = 3'd1,
    ST_SYS_UP    = 3'd2,
    ST_RUN       = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAM_LAST = CNT_W'(DRAM_DELAY_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_sync;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sys_rst_n;
  logic              r_dram_rst_n;
  logic              r_ready;
  logic              r_lock_lost;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_sys_nxt;
  logic              w_dram_nxt;
  logic              w_lost_nxt;

  // Lock synchroniser into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pll_lock};
    end
  end

  assign w_lock_sync = r_sync[SYNC_STAGES-1];

  // State, shared counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_WAIT_LOCK;
      r_cnt        <= '0;
      r_sys_rst_n  <= 1'b0;
      r_dram_rst_n <= 1'b0;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sys_rst_n  <= w_sys_nxt;
      r_dram_rst_n <= w_dram_nxt;
      r_ready      <= w_dram_nxt;
      r_lock_lost  <= w_lost_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sys_nxt   = r_sys_rst_n;
    w_dram_nxt  = r_dram_rst_n;
    w_lost_nxt  = r_lock_lost;
    case (r_state)
      ST_WAIT_LOCK: begin
        w_cnt_nxt  = '0;
        w_sys_nxt  = 1'b0;
        w_dram_nxt = 1'b0;
        if (w_lock_sync) begin
          w_state_nxt = ST_STABILIZE;
        end
      end
      ST_STABILIZE: begin
        if (!w_lock_sync) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt = ST_SYS_UP;
          w_sys_nxt   = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_SYS_UP: begin
        if (!w_lock_sync) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_sys_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DRAM_LAST) begin
          w_state_nxt = ST_RUN;
          w_dram_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_sync) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_sys_nxt   = 1'b0;
          w_dram_nxt  = 1'b0;
          w_lost_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_sys_nxt   = 1'b0;
        w_dram_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.sys_rst_n  = r_sys_rst_n;
  assign bus.dram_rst_n = r_dram_rst_n;
  assign bus.ready      = r_ready;
  assign bus.lock_lost  = r_lock_lost;
  assign bus.state_o    = r_state;

`ifdef PLL_RELOCK_CNT_EN
  logic [7:0] r_relock_cnt;

  // Saturating count of lock losses out of RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_relock_cnt <= '0;
    end else if ((r_state == ST_RUN) && (w_state_nxt == ST_WAIT_LOCK) &&
                 (r_relock_cnt != 8'hFF)) begin
      r_relock_cnt <= r_relock_cnt + 8'd1;
    end
  end

  assign bus.relock_cnt = r_relock_cnt;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the system rPLL wrapper (27 MHz in, 150 MHz clkout and lock out).
- Consumes the PLL's asynchronous lock signal in the 150 MHz clkout domain and generates ordered, glitch-free resets for the rest of the DRAM test design.
- Releases the system reset first, then the DRAM controller reset after a power-up delay.
- On any loss of lock, it forces all resets back into assertion.

Parameters:
- SYNC_STAGES, 2: flops in the pll_lock synchroniser; minimum 2.
- LOCK_STABLE_CYCLES, 1024: lock_sync must stay high this many consecutive cycles before sys_rst_n releases; minimum 1.
- DRAM_DELAY_CYCLES, 30000: cycles from sys_rst_n release to dram_rst_n release; 200 us at 150 MHz; minimum 1.
- CNT_W, 16: shared counter width; must hold max(LOCK_STABLE_CYCLES, DRAM_DELAY_CYCLES) - 1.

Ports:
- clk, input, 1: PLL clkout (150 MHz); all logic on rising edge.
- rst_n, input, 1: asynchronous active-low reset (board button / power-on).
- pll_lock, input, 1: raw PLL lock; asynchronous to clk.
- sys_rst_n, output, 1: active-low reset for general system logic; registered.
- dram_rst_n, output, 1: active-low reset for the DRAM controller and test engine; registered.
- ready, output, 1: high only in RUN.
- lock_lost, output, 1: sticky; set on any lock drop after the first RUN entry.
- state_o, output, 3: current FSM state, for debug/LEDs.

Behaviour:
- Reset is asynchronous and active-low on rst_n, with one clock domain (clk). On rst_n low:
  - Synchroniser flops cleared to 0.
  - State = WAIT_LOCK, counter = 0.
  - sys_rst_n = 0, dram_rst_n = 0, ready = 0, lock_lost = 0.
  - A mid-sequence rst_n assertion aborts immediately; there is no partial state retained.
- Synchroniser: pll_lock passes through SYNC_STAGES flops; the last stage is lock_sync. Only lock_sync is used by the FSM.
- State encodings: WAIT_LOCK = 0, STABILIZE = 1, SYS_UP = 2, RUN = 3. All outputs are registered and update on the same edge as the state.
- WAIT_LOCK:
  - Counter held at 0; all resets asserted.
  - If lock_sync = 1, go to STABILIZE with counter = 0.
- STABILIZE:
  - If lock_sync = 0, go to WAIT_LOCK and clear the counter (glitch rejection).
  - Else if counter == LOCK_STABLE_CYCLES-1, go to SYS_UP, set sys_rst_n = 1, counter = 0.
  - Else increment the counter.
- SYS_UP:
  - If lock_sync = 0, go to WAIT_LOCK with sys_rst_n = 0.
  - Else if counter == DRAM_DELAY_CYCLES-1, go to RUN, set dram_rst_n = 1, ready = 1.
  - Else increment the counter.
- RUN:
  - Holds while lock_sync = 1.
  - If lock_sync = 0, go to WAIT_LOCK: sys_rst_n = 0, dram_rst_n = 0, ready = 0, lock_lost = 1 on the same edge.
- Latency, with SYNC_STAGES = S, LOCK_STABLE_CYCLES = L, DRAM_DELAY_CYCLES = D:
  - pll_lock first sampled high at edge k, and held high.
  - sys_rst_n rises after edge k+S+L.
  - dram_rst_n and ready rise after edge k+S+L+D.
- Lock-loss latency: pll_lock sampled low at edge m; all resets asserted after edge m+S.
- Ordering invariants:
  - dram_rst_n = 1 implies sys_rst_n = 1.
  - ready == dram_rst_n at all times.
  - Neither output ever pulses high for a single cycle outside this sequence.
- Counter width: no wrap occurs when parameters are legal. Counter is compared for equality only.
- lock_lost is cleared only by rst_n.

Optional Feature:
- Macro: PLL_RELOCK_CNT_EN.
- Defined:
  - Adds output relock_cnt [7:0]; reset value 0.
  - Increments by 1 on each RUN -> WAIT_LOCK transition; saturates at 255.
  - Cleared only by rst_n.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
All scenarios use S = 2, L = 8, D = 16.
- Clean lock: rst_n released, pll_lock rises and is sampled at edge 10 -> sys_rst_n high after edge 20, dram_rst_n/ready high after edge 36, lock_lost = 0, state_o = 3.
- Lock glitch: pll_lock high for 5 cycles, low 1, then high -> STABILIZE restarts, sys_rst_n stays 0 through the glitch, and rises L cycles after lock_sync re-asserts.
- Loss in RUN: from RUN, drop pll_lock at edge m -> all three outputs low after edge m+2, lock_lost = 1, state_o = 0; re-lock reruns the full sequence; lock_lost stays 1.
- Loss in SYS_UP: drop pll_lock 5 cycles into SYS_UP -> sys_rst_n returns to 0 and dram_rst_n never goes high.
- Async reset mid-sequence: assert rst_n between clock edges during SYS_UP -> outputs 0 immediately (before the next edge); after release with lock held, the full L+D sequence repeats.
- With PLL_RELOCK_CNT_EN: 3 RUN -> lock-loss cycles -> relock_cnt = 3; force 260 losses -> relock_cnt = 255; rst_n -> 0.
